pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 32 +++
 rtl/link_stack.sv | 79 +++++++
 rtl/pc_sequencer.sv | 144 ++++++++++++++
 tb/tb_pc_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Purpose  : Shared constants and types for the program-counter sequencer.
//            Holds the default parameter values, the redirect-source
//            encoding and a small helper that says which sources flush.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

  localparam int DEF_PC_W        = 8;
  localparam int DEF_STACK_DEPTH = 4;
  localparam int DEF_CNT_W       = 8;

  // Where the next PC comes from when it is not a plain increment/hold.
  typedef enum logic [2:0] {
    NONE   = 3'd0,
    BRANCH = 3'd1,
    JUMP   = 3'd2,
    RET    = 3'd3,
    WRAP   = 3'd4
  } redirect_src_e;

  // WRAP is a sequential step from the last address back to 0, so the
  // instructions already fetched behind it are still valid: no flush.
  function automatic logic is_flush_src(input redirect_src_e src);
    return (src == BRANCH) || (src == JUMP) || (src == RET);
  endfunction

endpackage
`default_nettype wire

// File: rtl/link_stack.sv
`default_nettype none
// ============================================================================
// Module   : link_stack
// Purpose  : LIFO of return addresses for the PC sequencer.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            push, push_data- write push_data on top (visible next cycle)
//            pop            - remove top entry
//            top_data       - current top entry (0 when empty)
//            full, empty    - occupancy status
//            err            - sticky flag: pop on empty or push on full
// Notes    : push together with an accepted pop replaces the top entry, so
//            occupancy is unchanged and no overflow is reported even when
//            the stack is full.
// Revision : 1.0 - initial release
// ============================================================================
module link_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int PC_W        = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            full,
  output logic            empty,
  output logic            err
);

  localparam int             IDX_W   = $clog2(STACK_DEPTH);
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(STACK_DEPTH);

  logic [PC_W-1:0]  mem [STACK_DEPTH];
  logic [IDX_W:0]   count;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] free_idx;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign top_idx  = IDX_W'(count - 1'b1);
  assign free_idx = count[IDX_W-1:0];
  assign top_data = empty ? '0 : mem[top_idx];
  assign pop_ok   = pop && !empty;

  // Occupancy and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (pop && empty) begin
        err <= 1'b1;
      end
      if (push && full && !pop_ok) begin
        err <= 1'b1;
      end
      if (pop_ok && !push) begin
        count <= count - 1'b1;
      end else if (!pop_ok && push && !full) begin
        count <= count + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (pop_ok && push) begin
        mem[top_idx] <= push_data;
      end else if (!pop_ok && push && !full) begin
        mem[free_idx] <= push_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Next-PC selection for a simple pipelined core: MEM-stage BEQ
//            redirect, bounded jumps with a saturating taken-jump counter,
//            call/return through a link stack, and an end-of-program rule
//            that either wraps to 0 or halts.
// Ports    : clk, reset                 - clock, sync active-high reset
//            stall                      - hold PC
//            branch_taken/branch_target - BEQ redirect
//            jump_req/jump_target       - bounded jump request
//            jump_limit                 - max taken jumps (0 = unlimited)
//            count_clr                  - clear jump_count
//            link_push/link_addr        - push a return address
//            ret_pop                    - return to popped address
//            loop_mode                  - at END_ADDR: 1 wrap, 0 halt
//            pc                         - fetch address
//            flush                      - redirect accepted this cycle
//            halted                     - sticky halt flag
//            jump_count                 - taken-jump count (saturating)
//            stk_empty/stk_full/stk_err - link-stack status
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = DEF_PC_W,
  parameter int              STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int              CNT_W       = DEF_CNT_W,
  parameter logic [PC_W-1:0] END_ADDR    = {PC_W{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             jump_req,
  input  logic [PC_W-1:0]  jump_target,
  input  logic [CNT_W-1:0] jump_limit,
  input  logic             count_clr,
  input  logic             link_push,
  input  logic [PC_W-1:0]  link_addr,
  input  logic             ret_pop,
  input  logic             loop_mode,
  output logic [PC_W-1:0]  pc,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] jump_count,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             stk_err
);

  logic            jump_ok;
  logic            jump_taken;
  logic            pop_req;
  logic [PC_W-1:0] stk_top;
  logic [PC_W-1:0] redirect_pc;
  redirect_src_e   src;

  // --------------------------------------------------------------------------
  // Redirect arbitration. A jump that is over its limit does not count as a
  // request at all, so a same-cycle return may still win.
  // --------------------------------------------------------------------------
  always_comb begin
    jump_ok     = (jump_limit == '0) || (jump_count < jump_limit);
    jump_taken  = jump_req && jump_ok && !branch_taken;
    // The stack only sees the pop when nothing above it won; an unaccepted
    // pop on an empty stack still reaches it so the underflow is recorded.
    pop_req     = ret_pop && !branch_taken && !(jump_req && jump_ok);
    src         = NONE;
    redirect_pc = pc;
    if (branch_taken) begin
      src         = BRANCH;
      redirect_pc = branch_target;
    end else if (jump_req && jump_ok) begin
      src         = JUMP;
      redirect_pc = jump_target;
    end else if (ret_pop && !stk_empty) begin
      src         = RET;
      redirect_pc = stk_top;
    end else if (!halted && (pc == END_ADDR) && loop_mode) begin
      src         = WRAP;
      redirect_pc = '0;
    end
  end

  assign flush = !reset && is_flush_src(src);

  // --------------------------------------------------------------------------
  // PC and halt flag. Once halted the PC is frozen (it is sitting on
  // END_ADDR) until a flushing redirect releases it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      halted <= 1'b0;
    end else begin
      if (is_flush_src(src)) begin
        pc     <= redirect_pc;
        halted <= 1'b0;
      end else if (src == WRAP) begin
        pc <= redirect_pc;
      end else if (halted) begin
        pc <= pc;
      end else if (pc == END_ADDR) begin
        // loop_mode is low here, otherwise WRAP would have been selected.
        halted <= 1'b1;
      end else if (!stall) begin
        pc <= pc + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Taken-jump counter: clear beats increment, increment saturates.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      jump_count <= '0;
    end else if (count_clr) begin
      jump_count <= '0;
    end else if (jump_taken && (jump_count != {CNT_W{1'b1}})) begin
      jump_count <= jump_count + 1'b1;
    end
  end

  link_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .PC_W        (PC_W)
  ) u_link_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (link_push),
    .pop       (pop_req),
    .push_data (link_addr),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .err       (stk_err)
  );

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer. Directed scenarios
//            followed by randomized traffic, all compared against a
//            queue-based behavioural model of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int PC_W     = 8;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 8;
  localparam int END_A    = 255;
  localparam int PC_MOD   = 256;
  localparam int CNT_MAX  = 255;

  logic             clk;
  logic             reset;
  logic             stall;
  logic             branch_taken;
  logic [PC_W-1:0]  branch_target;
  logic             jump_req;
  logic [PC_W-1:0]  jump_target;
  logic [CNT_W-1:0] jump_limit;
  logic             count_clr;
  logic             link_push;
  logic [PC_W-1:0]  link_addr;
  logic             ret_pop;
  logic             loop_mode;
  logic [PC_W-1:0]  pc;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] jump_count;
  logic             stk_empty;
  logic             stk_full;
  logic             stk_err;

  pc_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (DEPTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_req      (jump_req),
    .jump_target   (jump_target),
    .jump_limit    (jump_limit),
    .count_clr     (count_clr),
    .link_push     (link_push),
    .link_addr     (link_addr),
    .ret_pop       (ret_pop),
    .loop_mode     (loop_mode),
    .pc            (pc),
    .flush         (flush),
    .halted        (halted),
    .jump_count    (jump_count),
    .stk_empty     (stk_empty),
    .stk_full      (stk_full),
    .stk_err       (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_pc;
  int m_halt;
  int m_cnt;
  int m_err;
  int stk[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock cycle: inputs are already driven (at the falling edge).
  task automatic tick();
    int jt_ok;
    int redir;
    int nxt;
    int popping;
    #1;
    jt_ok = (jump_req && (jump_limit == 0 || m_cnt < int'(jump_limit))) ? 1 : 0;
    redir = (!reset && (branch_taken || jt_ok != 0 || (ret_pop && stk.size() > 0))) ? 1 : 0;
    check("flush", {31'd0, flush}, redir);
    @(posedge clk);
    if (reset) begin
      m_pc = 0; m_halt = 0; m_cnt = 0; m_err = 0;
      stk.delete();
    end else begin
      if (branch_taken)                    nxt = int'(branch_target);
      else if (jt_ok != 0)                 nxt = int'(jump_target);
      else if (ret_pop && stk.size() > 0)  nxt = stk[$];
      else if (m_halt != 0)                nxt = m_pc;
      else if (m_pc == END_A)              nxt = loop_mode ? 0 : m_pc;
      else if (stall)                      nxt = m_pc;
      else                                 nxt = (m_pc + 1) % PC_MOD;

      if (redir != 0) m_halt = 0;
      else if (m_halt == 0 && m_pc == END_A && !loop_mode) m_halt = 1;

      if (count_clr) m_cnt = 0;
      else if (!branch_taken && jt_ok != 0 && m_cnt < CNT_MAX) m_cnt++;

      popping = (ret_pop && !branch_taken && jt_ok == 0) ? 1 : 0;
      if (popping != 0) begin
        if (stk.size() == 0) m_err = 1;
        else void'(stk.pop_back());
      end
      if (link_push) begin
        if (stk.size() < DEPTH) stk.push_back(int'(link_addr));
        else m_err = 1;
      end
      m_pc = nxt;
    end
    #1;
    check("pc",        pc,                     m_pc);
    check("halted",    {31'd0, halted},        m_halt);
    check("jump_count",jump_count,             m_cnt);
    check("stk_empty", {31'd0, stk_empty},     (stk.size() == 0) ? 1 : 0);
    check("stk_full",  {31'd0, stk_full},      (stk.size() == DEPTH) ? 1 : 0);
    check("stk_err",   {31'd0, stk_err},       m_err);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; branch_taken = 0; branch_target = '0;
    jump_req = 0; jump_target = '0; jump_limit = '0; count_clr = 0;
    link_push = 0; link_addr = '0; ret_pop = 0; loop_mode = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CNT_W-1:0] saved_cnt;
    m_pc = 0; m_halt = 0; m_cnt = 0; m_err = 0;
    idle_inputs();
    reset = 1;
    @(negedge clk);

    // Reset then straight-line fetch
    tick();
    check("reset_pc", pc, 0);
    check("reset_empty", {31'd0, stk_empty}, 1);
    reset = 0;
    repeat (5) tick();
    check("seq_pc5", pc, 5);

    // Bounded jumps: limit 2, three requests
    jump_limit = 8'd2; jump_target = 8'h10; jump_req = 1;
    repeat (3) tick();
    jump_req = 0;
    check("limit_cnt", jump_count, 2);
    check("limit_fallthru_pc", pc, 8'h11);

    // Unlimited jumps saturate the counter
    count_clr = 1; tick(); count_clr = 0;
    jump_limit = 8'd0; jump_req = 1;
    repeat (300) tick();
    jump_req = 0;
    check("sat_cnt", jump_count, 255);

    // count_clr beats a same-cycle increment
    jump_req = 1; count_clr = 1; tick(); jump_req = 0; count_clr = 0;
    check("clr_prec", jump_count, 0);

    // Link stack push/pop and underflow
    reset = 1; tick(); reset = 0;
    link_push = 1; link_addr = 8'h20; tick();
    link_addr = 8'h30; tick();
    link_push = 0; ret_pop = 1;
    tick(); check("pop1_pc", pc, 8'h30);
    tick(); check("pop2_pc", pc, 8'h20);
    tick(); check("pop3_pc", pc, 8'h21);
    ret_pop = 0;
    check("underflow_err", {31'd0, stk_err}, 1);

    // Push + pop in the same cycle replaces the top entry
    reset = 1; tick(); reset = 0;
    link_push = 1; link_addr = 8'h40; tick();
    link_addr = 8'h50; ret_pop = 1; tick();
    check("swap_pc", pc, 8'h40);
    link_push = 0; tick();
    check("swap_pop_pc", pc, 8'h50);
    ret_pop = 0;

    // Overflow
    reset = 1; tick(); reset = 0;
    link_push = 1;
    for (int i = 0; i < 5; i++) begin
      link_addr = 8'(8'h60 + i);
      tick();
    end
    link_push = 0;
    check("ovf_full", {31'd0, stk_full}, 1);
    check("ovf_err", {31'd0, stk_err}, 1);

    // End-of-program: halt, release by branch, then wrap
    branch_taken = 1; branch_target = 8'hFF; tick();
    branch_taken = 0; loop_mode = 0;
    repeat (2) tick();
    check("halt_flag", {31'd0, halted}, 1);
    check("halt_pc", pc, 8'hFF);
    branch_taken = 1; branch_target = 8'h05; tick();
    branch_taken = 0;
    check("unhalt_pc", pc, 8'h05);
    check("unhalt_flag", {31'd0, halted}, 0);
    branch_taken = 1; branch_target = 8'hFE; tick();
    branch_taken = 0; loop_mode = 1;
    repeat (2) tick();
    check("wrap_pc", pc, 0);
    loop_mode = 0;

    // Branch beats jump under stall; counter untouched
    saved_cnt = jump_count;
    stall = 1; branch_taken = 1; branch_target = 8'h33;
    jump_req = 1; jump_target = 8'h44; jump_limit = 0;
    tick();
    check("prio_pc", pc, 8'h33);
    check("prio_cnt", jump_count, saved_cnt);
    // Reset overrides a same-cycle redirect
    reset = 1; tick();
    check("rst_over_pc", pc, 0);
    idle_inputs();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 63) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_target = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255))
                                                  : 8'($urandom_range(0, 255));
      jump_req      = ($urandom_range(0, 5) == 0);
      jump_target   = 8'($urandom_range(0, 255));
      jump_limit    = 8'($urandom_range(0, 5));
      count_clr     = ($urandom_range(0, 15) == 0);
      link_push     = ($urandom_range(0, 4) == 0);
      link_addr     = 8'($urandom_range(0, 255));
      ret_pop       = ($urandom_range(0, 5) == 0);
      loop_mode     = ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
